// File: rtl/sync_fifo_ext.sv
// Synchronous FIFO with occupancy counter, almost-full/empty thresholds,
// sticky overflow/underflow flags, and selectable registered or fall-through read.
module sync_fifo_ext #(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 8,
  parameter int FWFT      = 0,
  parameter int AF_LEVEL  = DEPTH - 2,
  parameter int AE_LEVEL  = 2,
  parameter int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CLR,
  input  logic [WIDTH-1:0]     DATA_IN,
  input  logic                 WR_EN,
  input  logic                 RD_EN,
  output logic [WIDTH-1:0]     DATA_OUT,
  output logic                 VALID,
  output logic [PTR_WIDTH:0]   CNTR,
  output logic                 EMPTY,
  output logic                 FULL,
  output logic                 ALMOST_EMPTY,
  output logic                 ALMOST_FULL,
  output logic                 OVERFLOW,
  output logic                 UNDERFLOW
);

  localparam int CW = PTR_WIDTH + 1;
  localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);
  localparam logic [CW-1:0]        DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]        AF_C     = CW'(AF_LEVEL);
  localparam logic [CW-1:0]        AE_C     = CW'(AE_LEVEL);

  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        cntr_q, cntr_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;
  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [WIDTH-1:0]     mem_d [DEPTH];

  logic empty, full, rd_acc, wr_acc, rd_do, wr_do;

  assign empty  = (cntr_q == '0);
  assign full   = (cntr_q == DEPTH_C);
  assign rd_acc = RD_EN && !empty;
  assign wr_acc = WR_EN && (!full || rd_acc);
  // A flush cycle swallows both requests, including the memory write.
  assign rd_do  = rd_acc && !CLR;
  assign wr_do  = wr_acc && !CLR;

  assign CNTR         = cntr_q;
  assign EMPTY        = empty;
  assign FULL         = full;
  assign ALMOST_EMPTY = (cntr_q <= AE_C);
  assign ALMOST_FULL  = (cntr_q >= AF_C);
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = udf_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cntr_d   = cntr_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (CLR) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cntr_d   = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_do) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_WIDTH'(1);
      if (rd_do) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_WIDTH'(1);
      if (wr_do && !rd_do)      cntr_d = cntr_q + CW'(1);
      else if (rd_do && !wr_do) cntr_d = cntr_q - CW'(1);
      if (WR_EN && !wr_acc) ovf_d = 1'b1;
      if (RD_EN && empty)   udf_d = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_do && (wr_ptr_q == PTR_WIDTH'(i))) mem_d[i] = DATA_IN;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cntr_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cntr_q   <= cntr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head of queue is always visible; content is meaningless while empty.
      assign DATA_OUT = mem_q[rd_ptr_q];
      assign VALID    = !empty;
    end else begin : g_reg
      logic [WIDTH-1:0] dout_q, dout_d;
      logic             valid_q, valid_d;

      always_comb begin
        dout_d  = dout_q;
        valid_d = 1'b0;
        if (CLR) begin
          dout_d = '0;
        end else if (rd_do) begin
          dout_d  = mem_q[rd_ptr_q];
          valid_d = 1'b1;
        end
      end

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          dout_q  <= dout_d;
          valid_q <= valid_d;
        end
      end

      assign DATA_OUT = dout_q;
      assign VALID    = valid_q;
    end
  endgenerate

endmodule

// File: doc/sync_fifo_ext.md
SYNC_FIFO_EXT -- requirements
Module: sync_fifo_ext

Interface
REQ-001 Parameter DEPTH, default 8: number of storage entries; any integer >= 2, not only powers of two.
REQ-002 Parameter WIDTH, default 8: data word width in bits.
REQ-003 Parameter FWFT, default 0: 0 = registered read; 1 = first-word fall-through.
REQ-004 Parameter AF_LEVEL, default DEPTH-2: ALMOST_FULL threshold, 1..DEPTH.
REQ-005 Parameter AE_LEVEL, default 2: ALMOST_EMPTY threshold, 0..DEPTH-1.
REQ-006 Parameter PTR_WIDTH, default $clog2(DEPTH): pointer width.
REQ-007 One clock; reset is asynchronous and active-low; ports named CLK and RST.
REQ-008 CLK  in  1: clock; all state changes on its rising edge.
REQ-009 RST  in  1: asynchronous active-low reset.
REQ-010 CLR  in  1: synchronous flush, active-high.
REQ-011 DATA_IN  in  WIDTH: write data.
REQ-012 WR_EN  in  1: write request.
REQ-013 RD_EN  in  1: read request.
REQ-014 DATA_OUT  out  WIDTH: read data.
REQ-015 VALID  out  1: DATA_OUT holds a freshly read word (FWFT=0); equals !EMPTY (FWFT=1).
REQ-016 CNTR  out  PTR_WIDTH+1: current occupancy, 0..DEPTH.
REQ-017 EMPTY, FULL  out  1 each: CNTR==0 / CNTR==DEPTH, combinational from CNTR.
REQ-018 ALMOST_EMPTY, ALMOST_FULL  out  1 each: CNTR<=AE_LEVEL / CNTR>=AF_LEVEL, combinational.
REQ-019 OVERFLOW, UNDERFLOW  out  1 each: sticky error flags.

Function
REQ-020 Read accepted (rd_acc) SHALL be RD_EN && !EMPTY.
REQ-021 Write accepted (wr_acc) SHALL be WR_EN && (!FULL || rd_acc).
REQ-022 CNTR SHALL change by +1 on wr_acc only, -1 on rd_acc only, and hold when both or neither occur.
REQ-023 A write SHALL store DATA_IN at WR_PTR; WR_PTR SHALL advance on wr_acc and wrap from DEPTH-1 to 0.
REQ-024 RD_PTR SHALL advance on rd_acc and wrap from DEPTH-1 to 0.
REQ-025 FULL with rd_acc and WR_EN SHALL accept both: CNTR stays DEPTH, and the oldest word is read.
REQ-026 EMPTY with RD_EN and WR_EN SHALL accept only the write: CNTR becomes 1, and UNDERFLOW is set.
REQ-027 FWFT=0: on rd_acc, DATA_OUT SHALL load mem[RD_PTR] and VALID SHALL be 1 the next cycle (1-cycle latency); otherwise DATA_OUT holds and VALID=0.
REQ-028 FWFT=1: DATA_OUT SHALL show mem[RD_PTR] combinationally; the first word SHALL appear the cycle after its write edge; rd_acc pops it.
REQ-029 FWFT=1 with EMPTY: DATA_OUT SHALL be don't-care and VALID=0.
REQ-030 OVERFLOW SHALL set when WR_EN && !wr_acc, and hold until CLR or RST.
REQ-031 UNDERFLOW SHALL set when RD_EN && EMPTY, and hold until CLR or RST.
REQ-032 CLR SHALL have priority over WR_EN and RD_EN in its cycle: pointers, CNTR, VALID, OVERFLOW and UNDERFLOW go to 0; DATA_OUT goes to 0; memory is not cleared; requests in that cycle are ignored.
REQ-033 All arithmetic SHALL be unsigned; CNTR never exceeds DEPTH nor goes below 0.

Reset
REQ-034 RST low SHALL immediately force: pointers 0, CNTR 0, memory 0, DATA_OUT 0, VALID 0, OVERFLOW 0, UNDERFLOW 0.
REQ-035 Consequently, during reset EMPTY=1, FULL=0, ALMOST_EMPTY=1, and ALMOST_FULL=0.
REQ-036 Reset asserted mid-operation SHALL abandon in-flight requests; the first accepted write after release goes to entry 0.

Verification (DEPTH=8, WIDTH=8, AF_LEVEL=6, AE_LEVEL=2, FWFT=0 unless stated)
REQ-037 Reset pulse -> CNTR=0, EMPTY=1, ALMOST_EMPTY=1, FULL=0, DATA_OUT=0x00, flags=0.
REQ-038 Write 0x11..0x88 -> ALMOST_EMPTY=0 at CNTR=3; ALMOST_FULL=1 at CNTR=6; FULL=1 at CNTR=8. Then write 0x99 -> CNTR=8, OVERFLOW=1. Then read 8 times -> 0x11..0x88 in order, one cycle after each RD_EN, VALID=1 each.
REQ-039 At full, RD_EN+WR_EN with 0xA5 -> CNTR stays 8, DATA_OUT=oldest word; 0xA5 is read out last.
REQ-040 Empty, RD_EN alone -> UNDERFLOW=1, CNTR=0, VALID=0; then RD_EN+WR_EN 0x3C -> CNTR=1, VALID=0; next read -> 0x3C.
REQ-041 Wrap-around: 20 interleaved write/read pairs 0x01..0x14 -> data returned in order; pointers wrap past entry 7; CNTR never exceeds 1. Then CLR with CNTR=5 and WR_EN=1 -> CNTR=0, flags 0, EMPTY=1.
REQ-042 FWFT=1: write 0x5A -> DATA_OUT=0x5A and VALID=1 next cycle with no RD_EN. Then RD_EN -> EMPTY=1 and VALID=0 next cycle.
